// File: rtl/neo_sample_reader_if.sv
// Memory read port and psi output stream for the NEO sample reader.
// The reader uses the master side and the memory/consumer environment uses the slave side.
interface neo_sample_reader_if #(
    parameter int N  = 8,
    parameter int AW = 4
);
    logic        [AW-1:0]  raddr;
    logic signed [N-1:0]   rdata;
    logic                  neo_valid;
    logic                  neo_ready;
    logic signed [2*N-1:0] neo_data;

    modport master (
        output raddr,
        input  rdata,
        output neo_valid,
        output neo_data,
        input  neo_ready
    );

    modport slave (
        input  raddr,
        output rdata,
        input  neo_valid,
        input  neo_data,
        output neo_ready
    );
endinterface

// File: rtl/neo_sample_reader.sv
// Read-side controller for the NEO sample ring: fetches committed samples, keeps a
// 3-sample window and streams psi[n] = x[n]^2 - x[n-1]*x[n+1].
module neo_sample_reader #(
    parameter  int N  = 8,
    parameter  int M  = 16,
    localparam int AW = $clog2(M)
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr_commit,
    neo_sample_reader_if.master bus,
    output logic [AW:0]         level,
    output logic                overrun
);

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(M);
    localparam logic [AW-1:0] LP_LAST  = AW'(M-1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic        [AW-1:0]  r_raddr;
    logic        [AW-1:0]  r_rptr;
    logic        [AW:0]    r_level;
    logic        [1:0]     r_fill;
    logic signed [N-1:0]   r_sCur;
    logic signed [N-1:0]   r_sPrev;
    logic                  r_neoValid;
    logic signed [2*N-1:0] r_neoData;
    logic                  r_overrun;

    logic                  w_fetch;
    logic                  w_capture;
    logic                  w_accept;
    logic signed [N-1:0]   w_rdata;
    logic signed [2*N-1:0] w_curExt;
    logic signed [2*N-1:0] w_prevExt;
    logic signed [2*N-1:0] w_nextExt;
    logic signed [2*N-1:0] w_square;
    logic signed [2*N-1:0] w_cross;
    logic signed [2*N-1:0] w_psi;

    assign w_rdata   = bus.rdata;
    assign w_curExt  = {{N{r_sCur[N-1]}},  r_sCur};
    assign w_prevExt = {{N{r_sPrev[N-1]}}, r_sPrev};
    assign w_nextExt = {{N{w_rdata[N-1]}}, w_rdata};
    assign w_square  = w_curExt * w_curExt;
    assign w_cross   = w_prevExt * w_nextExt;
    // The exact difference always fits 2N signed bits, so a 2N-bit wrapping subtract is exact.
    assign w_psi     = w_square - w_cross;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_fetch     = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_fetch     = 1'b1;
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_nextState = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_nextState = (r_fill == 2'd2) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (r_neoValid && bus.neo_ready) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_raddr    <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_fill     <= '0;
            r_sCur     <= '0;
            r_sPrev    <= '0;
            r_neoValid <= 1'b0;
            r_neoData  <= '0;
            r_overrun  <= 1'b0;
        end else if (clear) begin
            r_raddr    <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_fill     <= '0;
            r_sCur     <= '0;
            r_sPrev    <= '0;
            r_neoValid <= 1'b0;
            r_neoData  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_raddr <= r_rptr;
                r_rptr  <= (r_rptr == LP_LAST) ? '0 : r_rptr + 1'b1;
            end

            // A commit into a full ring overwrites the oldest unread slot, even if it is being fetched.
            if (wr_commit && (r_level == LP_DEPTH)) begin
                r_overrun <= 1'b1;
            end
            if (wr_commit && !w_fetch && (r_level != LP_DEPTH)) begin
                r_level <= r_level + 1'b1;
            end else if (!wr_commit && w_fetch) begin
                r_level <= r_level - 1'b1;
            end

            if (w_capture) begin
                r_sPrev <= r_sCur;
                r_sCur  <= w_rdata;
                if (r_fill == 2'd2) begin
                    r_neoData  <= w_psi;
                    r_neoValid <= 1'b1;
                end else begin
                    r_fill <= r_fill + 1'b1;
                end
            end

            if (w_accept) begin
                r_neoValid <= 1'b0;
            end
        end
    end

    assign bus.raddr     = r_raddr;
    assign bus.neo_valid = r_neoValid;
    assign bus.neo_data  = r_neoData;
    assign level         = r_level;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_neo_sample_reader.sv
// Randomized and directed bench for neo_sample_reader against a behavioural model
// of the reader plus a plain psi formula over the committed sample list.
module tb_neo_sample_reader;

    localparam int N  = 8;
    localparam int M  = 16;
    localparam int AW = $clog2(M);

    logic          Clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          clear     = 1'b0;
    logic          wr_commit = 1'b0;
    logic [AW:0]   level;
    logic          overrun;

    neo_sample_reader_if #(.N(N), .AW(AW)) bus ();

    neo_sample_reader #(.N(N), .M(M)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .clear     (clear),
        .wr_commit (wr_commit),
        .bus       (bus),
        .level     (level),
        .overrun   (overrun)
    );

    always #5 Clk = ~Clk;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    logic signed [N-1:0] mem [M];
    int waddr = 0;
    int sent[$];
    int gotPsi[$];

    // Memory with a one-cycle registered read.
    always @(posedge Clk) bus.rdata <= mem[bus.raddr];

    // Behavioural model: phase 0 idle, 1 address issued, 2 data on rdata, 3 result waiting.
    int mLevel   = 0;
    int mRptr    = 0;
    int mRaddr   = 0;
    int mPhase   = 0;
    int mSample  = 0;
    int mData    = 0;
    bit mValid   = 1'b0;
    bit mOverrun = 1'b0;
    int mWin[$];

    task automatic modelReset();
        mLevel = 0; mRptr = 0; mRaddr = 0; mPhase = 0; mSample = 0;
        mData = 0; mValid = 1'b0; mOverrun = 1'b0;
        mWin.delete();
    endtask

    task automatic modelStep();
        bit fetchNow;
        int newLevel;
        fetchNow = (mPhase == 0) && (mLevel > 0);
        newLevel = mLevel - (fetchNow ? 1 : 0) + (wr_commit ? 1 : 0);
        if (wr_commit && mLevel == M) mOverrun = 1'b1;
        if (newLevel > M) newLevel = M;
        case (mPhase)
            0: if (fetchNow) begin
                   mRaddr = mRptr;
                   mRptr  = (mRptr + 1) % M;
                   mPhase = 1;
               end
            1: begin
                   mSample = int'(mem[mRaddr]);
                   mPhase  = 2;
               end
            2: begin
                   if (mWin.size() == 2) begin
                       mData  = mWin[1] * mWin[1] - mWin[0] * mSample;
                       mValid = 1'b1;
                       mPhase = 3;
                   end else begin
                       mPhase = 0;
                   end
                   mWin.push_back(mSample);
                   if (mWin.size() > 2) void'(mWin.pop_front());
               end
            default: if (bus.neo_ready) begin
                   mValid = 1'b0;
                   mPhase = 0;
               end
        endcase
        mLevel = newLevel;
    endtask

    always @(posedge Clk or negedge reset) begin
        if (!reset)     modelReset();
        else if (clear) modelReset();
        else            modelStep();
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare, sampled mid-cycle; also logs every psi the consumer accepts.
    always @(negedge Clk) begin
        if (checking) begin
            checkOutput("raddr",     int'(bus.raddr),            mRaddr);
            checkOutput("level",     int'(level),                mLevel);
            checkOutput("overrun",   int'(overrun),              int'(mOverrun));
            checkOutput("neo_valid", int'(bus.neo_valid),        int'(mValid));
            checkOutput("neo_data",  int'($signed(bus.neo_data)), mData);
            if (bus.neo_valid && bus.neo_ready && !clear && reset)
                gotPsi.push_back(int'($signed(bus.neo_data)));
        end
    end

    task automatic applyStimulus(input bit doCommit, input int sample, input bit ready);
        @(posedge Clk);
        #2;
        clear         = 1'b0;
        wr_commit     = doCommit;
        bus.neo_ready = ready;
        if (doCommit) begin
            mem[waddr] = sample[N-1:0];
            sent.push_back(sample);
            waddr = (waddr + 1) % M;
        end
    endtask

    task automatic pulseClear(input bit ready);
        @(posedge Clk);
        #2;
        clear         = 1'b1;
        wr_commit     = 1'b0;
        bus.neo_ready = ready;
        waddr = 0;
        sent.delete();
        gotPsi.delete();
        applyStimulus(1'b0, 0, ready);
    endtask

    task automatic pulseReset();
        reset     = 1'b0;
        wr_commit = 1'b0;
        clear     = 1'b0;
        waddr = 0;
        sent.delete();
        gotPsi.delete();
        @(posedge Clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b0, 0, 1'b1);
            if (mLevel == 0 && mPhase == 0 && !mValid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput({name, " drain timeout"}, 0, 1);
    endtask

    task automatic waitPhase(input string name, input int phase, input bit ready, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b0, 0, ready);
            if (mPhase == phase && (phase != 2 || mWin.size() == 2)) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput({name, " wait timeout"}, 0, 1);
    endtask

    task automatic checkPsiAt(input string name, input int idx, input int expected);
        if (idx < gotPsi.size()) checkOutput(name, gotPsi[idx], expected);
        else                     checkOutput({name, " missing"}, gotPsi.size(), idx + 1);
    endtask

    // Independent formula over the committed samples since the last flush.
    task automatic checkPsiSeries(input string name);
        int expCount;
        expCount = (sent.size() > 2) ? sent.size() - 2 : 0;
        checkOutput({name, " psi count"}, gotPsi.size(), expCount);
        for (int k = 0; k < gotPsi.size() && k + 2 < sent.size(); k++)
            checkOutput({name, " psi value"}, gotPsi[k],
                        sent[k+1] * sent[k+1] - sent[k] * sent[k+2]);
    endtask

    function automatic int randSample();
        return int'($urandom_range(255)) - 128;
    endfunction

    initial begin
        for (int i = 0; i < M; i++) mem[i] = '0;
        bus.neo_ready = 1'b1;
        #1;
        reset    = 1'b0;
        checking = 1'b1;
        repeat (2) @(posedge Clk);
        #2;
        reset = 1'b1;
        checkOutput("reset raddr", int'(bus.raddr), 0);
        checkOutput("reset level", int'(level), 0);
        checkOutput("reset valid", int'(bus.neo_valid), 0);

        // Basic window priming and two results.
        pulseClear(1'b1);
        applyStimulus(1'b1, 3, 1'b1);
        applyStimulus(1'b1, 5, 1'b1);
        waitDrain("t1a", 40);
        checkOutput("t1 primed no psi", gotPsi.size(), 0);
        applyStimulus(1'b1, 2, 1'b1);
        waitDrain("t1b", 40);
        checkPsiAt("t1 psi 3,5,2", 0, 19);
        applyStimulus(1'b1, 4, 1'b1);
        waitDrain("t1c", 40);
        checkPsiAt("t1 psi 5,2,4", 1, -16);

        // Extreme values.
        pulseClear(1'b1);
        applyStimulus(1'b1, -128, 1'b1);
        applyStimulus(1'b1, -128, 1'b1);
        applyStimulus(1'b1, 127, 1'b1);
        waitDrain("t2a", 60);
        checkPsiAt("t2 psi -128,-128,127", 0, 32640);
        pulseClear(1'b1);
        applyStimulus(1'b1, -128, 1'b1);
        applyStimulus(1'b1, -128, 1'b1);
        applyStimulus(1'b1, -128, 1'b1);
        waitDrain("t2b", 60);
        checkPsiAt("t2 psi -128 x3", 0, 0);

        // Pointer wrap with continuous draining.
        pulseClear(1'b1);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, randSample(), 1'b1);
            repeat (3) applyStimulus(1'b0, 0, 1'b1);
        end
        waitDrain("t3", 60);
        checkPsiSeries("t3");
        checkOutput("t3 final raddr", int'(bus.raddr), 7);
        checkOutput("t3 final level", int'(level), 0);

        // Backpressure: five samples pending behind a held result.
        pulseClear(1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, randSample(), 1'b0);
        repeat (20) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t4 level held", int'(level), 5);
        checkOutput("t4 valid held", int'(bus.neo_valid), 1);
        waitDrain("t4", 100);
        checkPsiSeries("t4");

        // Overrun while stalled, then commits overlapping fetches.
        pulseClear(1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, randSample(), 1'b0);
        repeat (3) applyStimulus(1'b0, 0, 1'b0);
        checkOutput("t5 level saturated", int'(level), 16);
        checkOutput("t5 overrun set", int'(overrun), 1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, randSample(), 1'b1);
        waitDrain("t5", 200);
        checkOutput("t5 overrun sticky", int'(overrun), 1);
        pulseClear(1'b1);
        checkOutput("t5 overrun cleared", int'(overrun), 0);
        checkOutput("t5 level cleared", int'(level), 0);

        // Reset in the middle of a result-producing capture.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10 + i, 1'b1);
        waitPhase("t6 capture", 2, 1'b1, 40);
        pulseReset();
        checkOutput("t6 reset valid", int'(bus.neo_valid), 0);
        checkOutput("t6 reset level", int'(level), 0);
        applyStimulus(1'b1, 7, 1'b1);
        applyStimulus(1'b1, -3, 1'b1);
        waitDrain("t6a", 40);
        checkOutput("t6 no psi after reset", gotPsi.size(), 0);
        applyStimulus(1'b1, 2, 1'b1);
        waitDrain("t6b", 40);
        checkPsiAt("t6 psi 7,-3,2", 0, -5);

        // Clear while a result is held.
        pulseClear(1'b0);
        applyStimulus(1'b1, 10, 1'b0);
        applyStimulus(1'b1, 20, 1'b0);
        applyStimulus(1'b1, 30, 1'b0);
        waitPhase("t6 hold", 3, 1'b0, 40);
        pulseClear(1'b1);
        checkOutput("t6 clear valid", int'(bus.neo_valid), 0);
        applyStimulus(1'b1, 5, 1'b1);
        applyStimulus(1'b1, 6, 1'b1);
        applyStimulus(1'b1, 7, 1'b1);
        waitDrain("t6c", 60);
        checkOutput("t6 psi count after clear", gotPsi.size(), 1);
        checkPsiAt("t6 psi 5,6,7", 0, 1);

        // Random commits and random backpressure, kept below overrun.
        pulseClear(1'b1);
        for (int i = 0; i < 400; i++)
            applyStimulus((mLevel < M - 2) && ($urandom_range(1) == 1), randSample(),
                          $urandom_range(3) != 0);
        waitDrain("t7", 200);
        checkPsiSeries("t7");

        repeat (2) applyStimulus(1'b0, 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
